// File: rtl/median_window_gen.sv
// -----------------------------------------------------------------------------
// median_window_gen
//   Sliding-window generator for the median filter datapath. Each handshake
//   takes one MAX_K-pixel column and shifts it into a MAX_K x MAX_K register
//   window. The window goes to the sorter centre-aligned and masked down to
//   the K x K active region that was chosen at line start. At the end of a
//   line the block inserts C empty columns so that the right-edge pixels
//   still reach the centre.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   win_sel    window size select, K = MAX_K-2*win_sel (min 3), taken at sol
//   in_col     column pixels, row r at [r*WIDTH +: WIDTH]
//   in_valid   in_col valid
//   in_sol     first column of a line (qualified by in_valid)
//   in_eol     last column of a line (qualified by in_valid)
//   in_ready   block can accept a column this cycle
//   out_win    entry(r,c) {flag,data} at [(r*MAX_K+c)*(WIDTH+1) +: WIDTH+1],
//              c=0 is the newest column
//   out_col    line position of the centre column of out_win
//   out_valid  out_win/out_col valid
//   out_ready  consumer accepts the window
//   err        sticky protocol error flag
// -----------------------------------------------------------------------------
module median_window_gen #(
  parameter int WIDTH = 9,
  parameter int MAX_K = 11,
  parameter int SEL_W = 2,
  parameter int COL_W = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [SEL_W-1:0]                   win_sel,
  input  logic [MAX_K*WIDTH-1:0]             in_col,
  input  logic                               in_valid,
  input  logic                               in_sol,
  input  logic                               in_eol,
  output logic                               in_ready,
  output logic [MAX_K*MAX_K*(WIDTH+1)-1:0]   out_win,
  output logic [COL_W-1:0]                   out_col,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               err
);

  localparam int C  = (MAX_K - 1) / 2;
  localparam int EW = WIDTH + 1;
  localparam int HW = $clog2(MAX_K);
  localparam int FW = $clog2(C + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                             state;
  logic [MAX_K-1:0][MAX_K-1:0][EW-1:0] win;
  logic [MAX_K-1:0]                   colv;
  logic [C:0][COL_W-1:0]              cpos;
  logic [COL_W-1:0]                   pos_cnt;
  logic [HW-1:0]                      h_reg;
  logic [HW-1:0]                      h_sel;
  logic [FW-1:0]                      flush_cnt;
  logic [MAX_K-1:0]                   act;
  int                                 k_sel;
  int                                 h_int;

  logic stall;
  logic accept;
  logic flush_step;
  logic advance;
  logic sol_acc;

  // Handshake. A held window blocks both new columns and flush steps, so the
  // window registers never move while the consumer is stalling. A column
  // that arrives while IDLE always starts a line, whether or not in_sol is set.
  always_comb begin
    stall      = out_valid & ~out_ready;
    in_ready   = (state != FLUSH) & ~stall;
    accept     = in_valid & in_ready;
    flush_step = (state == FLUSH) & ~stall;
    advance    = accept | flush_step;
    sol_acc    = accept & (in_sol | (state == IDLE));
  end

  // Decode win_sel into the window half-width h = (K-1)/2. K is clamped to 3.
  always_comb begin
    k_sel = MAX_K - 2 * int'(win_sel);
    if (k_sel < 3) begin
      k_sel = 3;
    end
    h_sel = HW'((k_sel - 1) / 2);
  end

  // Window shift register. A line start wipes the older columns so that two
  // lines never blend together. A flush step shifts in an empty column.
  // cpos follows the line position of each column up to the centre tap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win  <= '0;
      colv <= '0;
      cpos <= '0;
    end else if (advance) begin
      for (int r = 0; r < MAX_K; r++) begin
        for (int c = MAX_K - 1; c > 0; c--) begin
          win[r][c] <= sol_acc ? '0 : win[r][c-1];
        end
        win[r][0] <= accept ? {1'b1, in_col[r*WIDTH +: WIDTH]} : '0;
      end
      colv <= sol_acc ? {{(MAX_K-1){1'b0}}, 1'b1} : {colv[MAX_K-2:0], accept};
      for (int c = C; c > 0; c--) begin
        cpos[c] <= cpos[c-1];
      end
      cpos[0] <= sol_acc ? '0 : pos_cnt;
    end
  end

  // Line control: FSM, flush countdown, column counter, latched window size,
  // output valid and the sticky error flag. out_valid follows the column that
  // is about to land on the centre tap, which is colv[C-1] before the shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      pos_cnt   <= '0;
      h_reg     <= HW'(C);
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (advance) begin
        out_valid <= sol_acc ? 1'b0 : colv[C-1];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        pos_cnt <= sol_acc ? COL_W'(1) : pos_cnt + COL_W'(1);
        if (sol_acc) begin
          h_reg <= h_sel;
        end
        if ((in_sol && state == RUN) || (!in_sol && state == IDLE)) begin
          err <= 1'b1;
        end
        if (in_eol) begin
          state     <= FLUSH;
          flush_cnt <= FW'(C);
        end else if (sol_acc) begin
          state <= RUN;
        end
      end else if (flush_step) begin
        flush_cnt <= flush_cnt - FW'(1);
        if (flush_cnt == FW'(1)) begin
          state <= IDLE;
        end
      end
    end
  end

  // Mask the window down to the active K x K square around the centre.
  // Entries outside that square go out as all zeros.
  always_comb begin
    h_int   = int'(h_reg);
    act     = '0;
    out_win = '0;
    for (int i = 0; i < MAX_K; i++) begin
      act[i] = (i >= C - h_int) && (i <= C + h_int);
    end
    for (int r = 0; r < MAX_K; r++) begin
      for (int c = 0; c < MAX_K; c++) begin
        if (act[r] && act[c]) begin
          out_win[(r*MAX_K+c)*EW +: EW] = win[r][c];
        end
      end
    end
  end

  assign out_col = cpos[C];

endmodule
